spi_slave_ctrl: RTL
===================

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning the width of one received frame (2-bit command plus 8-bit payload).
REQ-002 SHALL have parameter TX_W, default 8, meaning the width of the read-data word shifted out on MISO.
REQ-003 SHALL have port clk  input  1  system clock; also the SPI bit clock; every rising edge is one bit time.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SS_n  input  1  slave select, active-low, frames a transaction.
REQ-006 SHALL have port MOSI  input  1  serial data from master, MSB first.
REQ-007 SHALL have port MISO  output  1  serial read data to master, MSB first.
REQ-008 SHALL have port rx_data  output  DATA_W  received frame to RAM; [9:8] is the command, [7:0] is the payload.
REQ-009 SHALL have port rx_valid  output  1  one-cycle strobe marking rx_data valid.
REQ-010 SHALL have port tx_data  input  TX_W  read data from RAM.
REQ-011 SHALL have port tx_valid  input  1  RAM strobe marking tx_data valid.

Function
REQ-012 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-013 IDLE SHALL go to CHK_CMD when SS_n=0, and otherwise SHALL stay in IDLE.
REQ-014 CHK_CMD SHALL sample MOSI as frame bit 9 and, while SS_n=0, SHALL transition as follows:
- MOSI=0 -> WRITE;
- MOSI=1 with rd_addr_seen=0 -> READ_ADD;
- MOSI=1 with rd_addr_seen=1 -> READ_DATA.
REQ-015 WRITE, READ_ADD and READ_DATA SHALL shift in MOSI bits 8..0 on the next 9 clocks, using a 4-bit bit counter.
REQ-016 The rising edge that samples the 10th bit SHALL register rx_data; rx_valid SHALL be 1 for exactly the following cycle.
REQ-017 After the 10th bit, further MOSI bits SHALL be ignored until the state returns to IDLE.
REQ-018 rx_valid with rx_data[9:8]=2'b10 SHALL set rd_addr_seen.
REQ-019 rx_valid with rx_data[9:8]=2'b11 SHALL clear rd_addr_seen.
REQ-020 In READ_DATA after rx_valid, the first cycle with tx_valid=1 SHALL load tx_data into an 8-bit output shifter.
REQ-021 The clock after that load SHALL drive MISO with tx_data[7]; MISO SHALL then present bits 7..0 on 8 consecutive cycles.
REQ-022 MISO SHALL be 0 at all other times.
REQ-023 tx_valid outside READ_DATA SHALL be ignored.
REQ-024 After the 8th MISO bit, the block SHALL hold MISO=0 until SS_n rises.
REQ-025 SS_n=1, sampled in any non-IDLE state, SHALL force IDLE on the next clock.
REQ-026 An SS_n abort SHALL clear the bit counter and the output shifter.
REQ-027 An SS_n abort SHALL suppress rx_valid for an incomplete frame.
REQ-028 An SS_n abort SHALL leave rd_addr_seen unchanged.
REQ-029 SS_n rising in the same cycle as the 10th bit SHALL still produce rx_valid, and the state SHALL then go to IDLE.
REQ-030 rx_data SHALL hold its last value between frames.

Reset
REQ-031 rst=1 at a rising clk edge SHALL set: state=IDLE, MISO=0, rx_valid=0, rx_data=0, rd_addr_seen=0, bit counter=0, output shifter=0.
REQ-032 Reset SHALL take priority over all other inputs, including mid-frame and mid-MISO shift.
REQ-033 After reset, the block SHALL require SS_n=0 sampled in IDLE before starting a new frame.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum, the command encodings (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11) and the DATA_W/TX_W constants.
REQ-035 The design SHALL contain one sub-module, spi_tx_shifter: an 8-bit parallel-load, MSB-first serializer with load, shift and clear inputs.
REQ-036 The FSM, input shift register and rd_addr_seen SHALL be in spi_slave_ctrl.

Verification
REQ-037 Write address: SS_n low, MOSI 00_0000_0101 -> rx_data=10'h005, rx_valid=1 for one cycle, 11 clocks after SS_n was sampled low; state returns to IDLE after SS_n high.
REQ-038 Write data: frame 01_1010_0101 -> rx_data=10'h1A5, single rx_valid pulse; rd_addr_seen stays 0.
REQ-039 Read address then read data: send frame 10_0000_0101; then a new frame with first bit 1 -> FSM enters READ_DATA, and frame 11_xxxx_xxxx gives rx_valid; tx_valid with tx_data=8'hC3 one cycle later -> MISO=1,1,0,0,0,0,1,1 on the next 8 cycles, and rd_addr_seen=0 afterwards.
REQ-040 Abort: SS_n high after 5 bits -> no rx_valid, IDLE next clock; the next full frame decodes correctly.
REQ-041 Reset mid-MISO shift: rst=1 during the 3rd MISO bit -> MISO=0 and state=IDLE on the next edge; rd_addr_seen=0.
REQ-042 Stray tx_valid=1 while in WRITE -> MISO stays 0 and the shifter is not loaded.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave controller.
//   state_t       : controller FSM states
//   CMD_*         : 2-bit command field found in rx_data[9:8]
//   SPI_DATA_W    : received frame width (command + payload)
//   SPI_TX_W      : read-data word width shifted out on MISO
package spi_pkg;

    localparam int SPI_DATA_W = 10;
    localparam int SPI_TX_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serializer for MISO read data.
//   clk, rst : system clock, synchronous active-high reset
//   load     : capture word; first bit appears on serial the following cycle
//   shift    : allows shifting while bits remain
//   clear    : synchronous flush of word, bit count and serial output
//   word     : parallel data to serialize
//   serial   : registered serial output, 0 whenever no bit is being presented
module spi_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         clear,
    input  logic [W-1:0] word,
    output logic         serial
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     sreg;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg      <= '0;
            remaining <= '0;
            serial    <= 1'b0;
        end else if (load) begin
            sreg      <= word;
            remaining <= CNT_W'(W);
            serial    <= 1'b0;
        end else if (shift && remaining != '0) begin
            serial    <= sreg[W-1];
            sreg      <= {sreg[W-2:0], 1'b0};
            remaining <= remaining - 1'b1;
        end else begin
            // Exhausted or not shifting: line idles low.
            serial    <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: receives 10-bit frames (2-bit command + 8-bit
// payload) on MOSI and returns an 8-bit read word on MISO. clk doubles as
// the SPI bit clock.
//   clk, rst  : clock, synchronous active-high reset
//   SS_n      : active-low slave select framing a transaction
//   MOSI      : serial input, MSB first
//   MISO      : serial read data, MSB first, 0 when idle
//   rx_data   : last received frame, [9:8] command, [7:0] payload
//   rx_valid  : one-cycle strobe for a newly received frame
//   tx_data   : read data from RAM
//   tx_valid  : strobe qualifying tx_data, honoured only in READ_DATA
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int TX_W   = SPI_TX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [TX_W-1:0]   tx_data,
    input  logic              tx_valid
);

    localparam logic [3:0] LAST_BIT   = 4'(DATA_W - 1);
    localparam logic [3:0] FRAME_DONE = 4'(DATA_W);

    state_t            state;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] next_frame;
    logic [3:0]        bit_cnt;
    logic              rd_addr_seen;
    logic              tx_started;
    logic              tx_load;
    logic              tx_clear;
    logic              tx_shift;

    always_comb begin
        next_frame = {shreg, MOSI};
        tx_shift   = (state == READ_DATA);
        tx_clear   = (state != IDLE) && SS_n;
        // Only one load per transaction, and only once the frame is complete.
        tx_load    = (state == READ_DATA) && !SS_n && (bit_cnt == FRAME_DONE)
                     && !tx_started && tx_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_started   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (rx_valid) begin
                if (rx_data[DATA_W-1 -: 2] == CMD_RD_ADDR) begin
                    rd_addr_seen <= 1'b1;
                end else if (rx_data[DATA_W-1 -: 2] == CMD_RD_DATA) begin
                    rd_addr_seen <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    bit_cnt    <= '0;
                    tx_started <= 1'b0;
                    if (!SS_n) begin
                        state <= CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    if (SS_n) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else begin
                        shreg   <= next_frame[DATA_W-2:0];
                        bit_cnt <= 4'd1;
                        if (!MOSI) begin
                            state <= WRITE;
                        end else if (rd_addr_seen) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    // The final bit is captured even when SS_n rises with it.
                    if (bit_cnt < FRAME_DONE) begin
                        shreg   <= next_frame[DATA_W-2:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= next_frame;
                            rx_valid <= 1'b1;
                        end
                    end
                    if (tx_load) begin
                        tx_started <= 1'b1;
                    end
                    if (SS_n) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        tx_started <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    spi_tx_shifter #(
        .W (TX_W)
    ) u_tx_shifter (
        .clk    (clk),
        .rst    (rst),
        .load   (tx_load),
        .shift  (tx_shift),
        .clear  (tx_clear),
        .word   (tx_data),
        .serial (MISO)
    );

endmodule
